pipe_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline registers (F/D/E/M/W).

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_hazard_ctrl_if.sv | 57 +++++
 rtl/pipe_fwd_unit.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller.
// State encoding and forwarding-select codes.
package pipe_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M is newer than W, so it wins when both match
  function automatic logic [1:0] fwd_enc(
    input logic hit_m,
    input logic hit_w
  );
    if (hit_m) begin
      return FWD_M;
    end else if (hit_w) begin
      return FWD_W;
    end else begin
      return FWD_RF;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle.
// master: pipeline side, slave: controller side.
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = 4
);

  logic [REG_W-1:0] ra1_d;
  logic [REG_W-1:0] ra2_d;
  logic [REG_W-1:0] ra1_e;
  logic [REG_W-1:0] ra2_e;
  logic [REG_W-1:0] wa_e;
  logic [REG_W-1:0] wa_m;
  logic [REG_W-1:0] wa_w;
  logic             regwrite_e;
  logic             regwrite_m;
  logic             regwrite_w;
  logic             memtoreg_e;
  logic             branch_taken_e;
  logic             mc_start_e;
  logic             mc_done;

  logic             stall_f;
  logic             stall_d;
  logic             stall_e;
  logic             flush_d;
  logic             flush_e;
  logic             flush_m;
  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             mc_busy;
  logic             mc_timeout;

  modport master (
    output ra1_d, ra2_d, ra1_e, ra2_e,
    output wa_e, wa_m, wa_w,
    output regwrite_e, regwrite_m, regwrite_w,
    output memtoreg_e, branch_taken_e,
    output mc_start_e, mc_done,
    input  stall_f, stall_d, stall_e,
    input  flush_d, flush_e, flush_m,
    input  fwd_a_e, fwd_b_e,
    input  mc_busy, mc_timeout
  );

  modport slave (
    input  ra1_d, ra2_d, ra1_e, ra2_e,
    input  wa_e, wa_m, wa_w,
    input  regwrite_e, regwrite_m, regwrite_w,
    input  memtoreg_e, branch_taken_e,
    input  mc_start_e, mc_done,
    output stall_f, stall_d, stall_e,
    output flush_d, flush_e, flush_m,
    output fwd_a_e, fwd_b_e,
    output mc_busy, mc_timeout
  );

endinterface

// File: rtl/pipe_fwd_unit.sv
// Compares one source register against the M and W writers.
// Yields per-stage hits and the encoded operand select.
module pipe_fwd_unit
  import pipe_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int PC_REG = 15
) (
  input  logic [REG_W-1:0] ra,
  input  logic [REG_W-1:0] wa_m,
  input  logic [REG_W-1:0] wa_w,
  input  logic             regwrite_m,
  input  logic             regwrite_w,
  output logic             hit,
  output logic [1:0]       sel
);

  logic not_pc;
  logic hit_m;
  logic hit_w;

  assign not_pc = (ra != REG_W'(PC_REG));
  assign hit_m  = regwrite_m && (wa_m == ra) && not_pc;
  assign hit_w  = regwrite_w && (wa_w == ra) && not_pc;
  assign hit    = hit_m || hit_w;
  assign sel    = fwd_enc(hit_m, hit_w);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage hazard controller: stall/flush, forwarding, mul/div wait FSM.
// Define PIPE_HAZARD_FWD_EN for forwarding; otherwise D-stage hits stall.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W      = 4,
  parameter int PC_REG     = 15,
  parameter int MC_TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  hz
);

  localparam int CNT_W = (MC_TIMEOUT > 2) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MC_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mc_timeout_q, mc_timeout_d;

  logic             hit_e_1d;
  logic             hit_e_2d;
  logic             d_hazard;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  assign hit_e_1d = hz.regwrite_e && (hz.wa_e == hz.ra1_d) &&
                    (hz.ra1_d != REG_W'(PC_REG));
  assign hit_e_2d = hz.regwrite_e && (hz.wa_e == hz.ra2_d) &&
                    (hz.ra2_d != REG_W'(PC_REG));

`ifdef PIPE_HAZARD_FWD_EN
  logic hit_a_unused;
  logic hit_b_unused;

  pipe_fwd_unit #(
    .REG_W  (REG_W),
    .PC_REG (PC_REG)
  ) u_fwd_a (
    .ra         (hz.ra1_e),
    .wa_m       (hz.wa_m),
    .wa_w       (hz.wa_w),
    .regwrite_m (hz.regwrite_m),
    .regwrite_w (hz.regwrite_w),
    .hit        (hit_a_unused),
    .sel        (fwd_a)
  );

  pipe_fwd_unit #(
    .REG_W  (REG_W),
    .PC_REG (PC_REG)
  ) u_fwd_b (
    .ra         (hz.ra2_e),
    .wa_m       (hz.wa_m),
    .wa_w       (hz.wa_w),
    .regwrite_m (hz.regwrite_m),
    .regwrite_w (hz.regwrite_w),
    .hit        (hit_b_unused),
    .sel        (fwd_b)
  );

  assign d_hazard = hz.memtoreg_e && (hit_e_1d || hit_e_2d);
`else
  logic       hit_mw_1d;
  logic       hit_mw_2d;
  logic [1:0] sel_1d_unused;
  logic [1:0] sel_2d_unused;
  logic       nofwd_unused;

  // Same comparators, aimed at D: any older writer forces a stall
  pipe_fwd_unit #(
    .REG_W  (REG_W),
    .PC_REG (PC_REG)
  ) u_hit_1d (
    .ra         (hz.ra1_d),
    .wa_m       (hz.wa_m),
    .wa_w       (hz.wa_w),
    .regwrite_m (hz.regwrite_m),
    .regwrite_w (hz.regwrite_w),
    .hit        (hit_mw_1d),
    .sel        (sel_1d_unused)
  );

  pipe_fwd_unit #(
    .REG_W  (REG_W),
    .PC_REG (PC_REG)
  ) u_hit_2d (
    .ra         (hz.ra2_d),
    .wa_m       (hz.wa_m),
    .wa_w       (hz.wa_w),
    .regwrite_m (hz.regwrite_m),
    .regwrite_w (hz.regwrite_w),
    .hit        (hit_mw_2d),
    .sel        (sel_2d_unused)
  );

  assign nofwd_unused = ^{hz.ra1_e, hz.ra2_e, hz.memtoreg_e};
  assign fwd_a        = FWD_RF;
  assign fwd_b        = FWD_RF;
  assign d_hazard     = hit_e_1d || hit_e_2d || hit_mw_1d || hit_mw_2d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mc_timeout_d = mc_timeout_q;
    hz.stall_f   = 1'b0;
    hz.stall_d   = 1'b0;
    hz.stall_e   = 1'b0;
    hz.flush_d   = 1'b0;
    hz.flush_e   = 1'b0;
    hz.flush_m   = 1'b0;
    hz.fwd_a_e   = fwd_a;
    hz.fwd_b_e   = fwd_b;
    if (reset) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
      hz.flush_m = 1'b1;
      hz.fwd_a_e = FWD_RF;
      hz.fwd_b_e = FWD_RF;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hz.branch_taken_e) begin
            hz.flush_d = 1'b1;
            hz.flush_e = 1'b1;
          end else if (d_hazard) begin
            hz.stall_f = 1'b1;
            hz.stall_d = 1'b1;
            hz.flush_e = 1'b1;
          end else if (hz.mc_start_e) begin
            state_d = MC_WAIT;
            cnt_d   = '0;
          end
        end
        MC_WAIT: begin
          // E holds the mc op; a bubble drains into M meanwhile
          hz.stall_f = 1'b1;
          hz.stall_d = 1'b1;
          hz.stall_e = 1'b1;
          hz.flush_m = 1'b1;
          if (hz.mc_done) begin
            state_d = RUN;
          end else if (cnt_q == CNT_MAX) begin
            state_d      = RUN;
            mc_timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      mc_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mc_timeout_q <= mc_timeout_d;
    end
  end

  assign hz.mc_busy    = (state_q == MC_WAIT) && !reset;
  assign hz.mc_timeout = mc_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (MC_TIMEOUT=8).
// Expectations adapt to PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic       sf;
    logic       sd;
    logic       se;
    logic       fd;
    logic       fe;
    logic       fm;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
    logic       to;
  } exp_t;

`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  exp_t exp_q[$];
  string tag_q[$];

  pipe_hazard_ctrl_if #(.REG_W(4)) hz ();

  pipe_hazard_ctrl #(
    .REG_W      (4),
    .PC_REG     (15),
    .MC_TIMEOUT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(
    logic sf, logic sd, logic se,
    logic fd, logic fe, logic fm,
    logic [1:0] fa, logic [1:0] fb,
    logic busy, logic to
  );
    exp_t e;
    e = '{sf, sd, se, fd, fe, fm, fa, fb, busy, to};
    return e;
  endfunction

  function automatic exp_t idle(logic to);
    return mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, to);
  endfunction

  function automatic exp_t waiting(logic to);
    return mk(1, 1, 1, 0, 0, 1, 2'b00, 2'b00, 1, to);
  endfunction

  function automatic exp_t in_rst(logic to);
    return mk(0, 0, 0, 1, 1, 1, 2'b00, 2'b00, 0, to);
  endfunction

  task automatic clr();
    hz.ra1_d = '0; hz.ra2_d = '0;
    hz.ra1_e = '0; hz.ra2_e = '0;
    hz.wa_e  = '0; hz.wa_m  = '0; hz.wa_w = '0;
    hz.regwrite_e = 0; hz.regwrite_m = 0;
    hz.regwrite_w = 0; hz.memtoreg_e = 0;
    hz.branch_taken_e = 0;
    hz.mc_start_e = 0; hz.mc_done = 0;
  endtask

  // inputs already driven; push, sample mid-cycle, pop, compare
  task automatic cyc(string tag, exp_t e);
    exp_t o;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    o = '{hz.stall_f, hz.stall_d, hz.stall_e,
          hz.flush_d, hz.flush_e, hz.flush_m,
          hz.fwd_a_e, hz.fwd_b_e, hz.mc_busy, hz.mc_timeout};
    chk(tag_q.pop_front(), 32'(o), 32'(exp_q.pop_front()));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cyc("rst", in_rst(0));
    reset = 1'b0;
    cyc("idle", idle(0));

    // load-use
    hz.memtoreg_e = 1; hz.regwrite_e = 1; hz.wa_e = 4'd3; hz.ra1_d = 4'd3;
    cyc("lu", mk(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));
    clr();
    cyc("lu_rel", idle(0));

    // forwarding
    hz.regwrite_m = 1; hz.wa_m = 4'd5;
    hz.regwrite_w = 1; hz.wa_w = 4'd5; hz.ra1_e = 4'd5;
    cyc("fwd_m", mk(0, 0, 0, 0, 0, 0, FWD ? 2'b10 : 2'b00, 2'b00, 0, 0));
    hz.regwrite_m = 0; hz.ra1_e = 4'd0; hz.ra2_e = 4'd5;
    cyc("fwd_w", mk(0, 0, 0, 0, 0, 0, 2'b00, FWD ? 2'b01 : 2'b00, 0, 0));
    hz.regwrite_m = 1; hz.wa_m = 4'd15; hz.wa_w = 4'd15;
    hz.ra1_e = 4'd15; hz.ra2_e = 4'd0;
    cyc("fwd_pc", idle(0));
    clr();

    // branch beats load-use
    hz.memtoreg_e = 1; hz.regwrite_e = 1; hz.wa_e = 4'd3; hz.ra1_d = 4'd3;
    hz.branch_taken_e = 1;
    cyc("br_lu", mk(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0));
    clr();

    // multicycle, done on 4th wait cycle; branch ignored while waiting
    hz.mc_start_e = 1;
    cyc("mc_start", idle(0));
    clr();
    cyc("mc_w1", waiting(0));
    hz.branch_taken_e = 1;
    cyc("mc_w2_br", waiting(0));
    clr();
    cyc("mc_w3", waiting(0));
    hz.mc_done = 1;
    cyc("mc_w4_done", waiting(0));
    clr();
    cyc("mc_release", idle(0));

    // timeout after 8 wait cycles
    hz.mc_start_e = 1;
    cyc("to_start", idle(0));
    clr();
    for (int i = 0; i < 8; i++) begin
      cyc($sformatf("to_w%0d", i + 1), waiting(0));
    end
    cyc("to_exit", idle(1));
    cyc("to_sticky", idle(1));

    // reset in MC_WAIT cycle 2, with mc_done ignored
    reset = 1;
    cyc("rst2_hold", in_rst(1));
    reset = 0;
    cyc("rst2_clr", idle(0));
    hz.mc_start_e = 1;
    cyc("rw_start", idle(0));
    clr();
    cyc("rw_w1", waiting(0));
    reset = 1; hz.mc_done = 1;
    cyc("rw_w2_rst", in_rst(0));
    reset = 0; hz.mc_done = 0;
    cyc("rw_run", idle(0));

    // W-stage hit in D: stalls only without forwarding
    hz.regwrite_w = 1; hz.wa_w = 4'd2; hz.ra2_d = 4'd2;
    cyc("d_hit_w", FWD ? idle(0) : mk(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 0, 0));
    clr();
    cyc("d_hit_rel", idle(0));
    hz.regwrite_w = 1; hz.wa_w = 4'd15; hz.ra1_d = 4'd15;
    cyc("d_hit_pc", idle(0));
    clr();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
